// File: rtl/alu_br_resolve_if.sv
// Bundles the ALU mispredict reports coming in and the kill mask and fetch
// redirect going out, for the commit-side branch resolver.
interface alu_br_resolve_if #(
   parameter int NALU     = 2,
   parameter int NCOMMIT  = 32,
   parameter int LNCOMMIT = 5,
   parameter int RV       = 64,
   parameter int BDEC     = 4
);
   logic [LNCOMMIT-1:0]      commit_head;
   logic [NALU-1:0]          alu_br_enable;
   logic [NALU*(RV-1)-1:0]   alu_br;
   logic [NALU*LNCOMMIT-1:0] alu_br_addr;
   logic [NALU-1:0]          alu_br_short;
   logic [NALU*(BDEC-1)-1:0] alu_br_dec;
   logic [NCOMMIT-1:0]       commit_kill_0;
   logic                     redirect_valid;
   logic                     redirect_ready;
   logic [RV-2:0]            redirect_pc;
   logic [LNCOMMIT-1:0]      redirect_addr;
   logic                     redirect_short;
   logic [BDEC-2:0]          redirect_dec;

   modport master (
      output commit_head, alu_br_enable, alu_br, alu_br_addr, alu_br_short,
             alu_br_dec, redirect_ready,
      input  commit_kill_0, redirect_valid, redirect_pc, redirect_addr,
             redirect_short, redirect_dec
   );

   modport slave (
      input  commit_head, alu_br_enable, alu_br, alu_br_addr, alu_br_short,
             alu_br_dec, redirect_ready,
      output commit_kill_0, redirect_valid, redirect_pc, redirect_addr,
             redirect_short, redirect_dec
   );
endinterface

// File: rtl/alu_br_resolve.sv
// Keeps the oldest ALU mispredict relative to the commit head, drives the
// wrong-path kill mask and holds the fetch redirect until it is accepted.
module alu_br_resolve #(
   parameter int NALU     = 2,
   parameter int NCOMMIT  = 32,
   parameter int LNCOMMIT = 5,
   parameter int RV       = 64,
   parameter int BDEC     = 4
) (
   input  logic            clk,
   input  logic            reset,
   alu_br_resolve_if.slave bus
);

   typedef enum logic {IDLE, PEND} state_e;

   state_e              state_q, state_d;
   logic [NCOMMIT-1:0]  kill_q, kill_d;
   logic [RV-2:0]       pc_q;
   logic [LNCOMMIT-1:0] addr_q;
   logic                short_q;
   logic [BDEC-2:0]     dec_q;

   logic                winFound;
   logic [LNCOMMIT-1:0] winAge;
   logic [LNCOMMIT-1:0] winAddr;
   logic [RV-2:0]       winPc;
   logic                winShort;
   logic [BDEC-2:0]     winDec;
   logic [LNCOMMIT-1:0] pendAge;
   logic                load;
   logic                clear;

   // Candidates already under the current mask are wrong-path and dropped;
   // strict less-than keeps the lowest ALU index on an age tie.
   always_comb begin
      logic [LNCOMMIT-1:0] addrK;
      logic [LNCOMMIT-1:0] ageK;
      winFound = 1'b0;
      winAge   = '1;
      winAddr  = '0;
      winPc    = '0;
      winShort = 1'b0;
      winDec   = '0;
      addrK    = '0;
      ageK     = '0;
      for (int k = 0; k < NALU; k++) begin
         addrK = bus.alu_br_addr[k*LNCOMMIT +: LNCOMMIT];
         ageK  = addrK - bus.commit_head;
         if (bus.alu_br_enable[k] && !kill_q[addrK] && (!winFound || ageK < winAge)) begin
            winFound = 1'b1;
            winAge   = ageK;
            winAddr  = addrK;
            winPc    = bus.alu_br[k*(RV-1) +: (RV-1)];
            winShort = bus.alu_br_short[k];
            winDec   = bus.alu_br_dec[k*(BDEC-1) +: (BDEC-1)];
         end
      end
   end

   always_comb begin
      kill_d = '0;
      for (int i = 0; i < NCOMMIT; i++) begin
         kill_d[i] = (LNCOMMIT'(i) - bus.commit_head) > winAge;
      end
   end

   assign pendAge = addr_q - bus.commit_head;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A survivor at handshake time always reloads; without ready only a
   // strictly older branch may replace the pending one.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      clear   = 1'b0;
      case (state_q)
         IDLE: begin
            if (winFound) begin
               load    = 1'b1;
               state_d = PEND;
            end
         end
         PEND: begin
            if (bus.redirect_ready) begin
               if (winFound) begin
                  load = 1'b1;
               end else begin
                  clear   = 1'b1;
                  state_d = IDLE;
               end
            end else if (winFound && (winAge < pendAge)) begin
               load = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         kill_q  <= '0;
         pc_q    <= '0;
         addr_q  <= '0;
         short_q <= 1'b0;
         dec_q   <= '0;
      end else if (load) begin
         kill_q  <= kill_d;
         pc_q    <= winPc;
         addr_q  <= winAddr;
         short_q <= winShort;
         dec_q   <= winDec;
      end else if (clear) begin
         kill_q  <= '0;
      end
   end

   always_comb begin
      bus.redirect_valid = (state_q == PEND);
      bus.commit_kill_0  = kill_q;
      bus.redirect_pc    = pc_q;
      bus.redirect_addr  = addr_q;
      bus.redirect_short = short_q;
      bus.redirect_dec   = dec_q;
   end

endmodule

// File: tb/tb_alu_br_resolve.sv
// Directed scenarios for alu_br_resolve; expectations are queued per cycle
// and a separate monitor compares them against the registered outputs.
module tb_alu_br_resolve;

   typedef struct {
      int          cyc;
      bit          chkPay;
      logic        valid;
      logic [62:0] pc;
      logic [4:0]  addr;
      logic        sh;
      logic [2:0]  dec;
      logic [31:0] mask;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cycleCount = 0;
   int   testsRun = 0;
   int   failCount = 0;
   exp_t scoreQ[$];

   alu_br_resolve_if bus ();

   alu_br_resolve dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount = cycleCount + 1;

   task automatic checkOutput(input exp_t e);
      bit bad;
      bad = (bus.redirect_valid !== e.valid) || (bus.commit_kill_0 !== e.mask);
      if (e.chkPay) begin
         bad = bad || (bus.redirect_pc !== e.pc) || (bus.redirect_addr !== e.addr) ||
               (bus.redirect_short !== e.sh) || (bus.redirect_dec !== e.dec);
      end
      testsRun++;
      if (bad) begin
         failCount++;
         $display("[TB] FAIL cycle%0d: got v=%0b pc=%h addr=%0d sh=%0b dec=%0d mask=%h, want v=%0b pc=%h addr=%0d sh=%0b dec=%0d mask=%h",
                  e.cyc, bus.redirect_valid, bus.redirect_pc, bus.redirect_addr,
                  bus.redirect_short, bus.redirect_dec, bus.commit_kill_0,
                  e.valid, e.pc, e.addr, e.sh, e.dec, e.mask);
      end
   endtask

   // Monitor: pops the expectation tagged for the cycle just registered.
   always @(negedge clk) begin
      if (scoreQ.size() > 0) begin
         if (scoreQ[0].cyc == cycleCount) begin
            checkOutput(scoreQ.pop_front());
         end else if (scoreQ[0].cyc < cycleCount) begin
            exp_t stale;
            stale = scoreQ.pop_front();
            testsRun++;
            failCount++;
            $display("[TB] FAIL missed cycle%0d: got no check, want check at cycle %0d", stale.cyc, stale.cyc);
         end
      end
   end

   task automatic setAlu(input int k, input logic [4:0] addr, input logic [62:0] pc,
                         input logic sh, input logic [2:0] dec);
      bus.alu_br_enable[k]      = 1'b1;
      bus.alu_br_addr[k*5 +: 5] = addr;
      bus.alu_br[k*63 +: 63]    = pc;
      bus.alu_br_short[k]       = sh;
      bus.alu_br_dec[k*3 +: 3]  = dec;
   endtask

   task automatic applyStimulus(input bit chkPay, input logic v, input logic [62:0] pc,
                                input logic [4:0] addr, input logic sh,
                                input logic [2:0] dec, input logic [31:0] mask);
      exp_t e;
      e.cyc = cycleCount + 1;
      e.chkPay = chkPay;
      e.valid = v;
      e.pc = pc;
      e.addr = addr;
      e.sh = sh;
      e.dec = dec;
      e.mask = mask;
      scoreQ.push_back(e);
      @(posedge clk);
      #1;
      bus.alu_br_enable = '0;
   endtask

   initial begin
      bus.commit_head    = '0;
      bus.alu_br_enable  = '0;
      bus.alu_br         = '0;
      bus.alu_br_addr    = '0;
      bus.alu_br_short   = '0;
      bus.alu_br_dec     = '0;
      bus.redirect_ready = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1, 0, 63'h0, 0, 0, 0, 32'h0);
      reset = 1'b0;

      // Single report then handshake
      setAlu(0, 5, 63'h1000, 1, 3'd3);
      applyStimulus(1, 1, 63'h1000, 5, 1, 3, 32'hFFFF_FFC0);
      bus.redirect_ready = 1'b1;
      applyStimulus(0, 0, 63'h0, 0, 0, 0, 32'h0);
      bus.redirect_ready = 1'b0;

      // Simultaneous reports across the wrap: addr 31 is older than addr 2
      bus.commit_head = 5'd30;
      setAlu(0, 2, 63'h2222, 1, 3'd1);
      setAlu(1, 31, 63'h3333, 0, 3'd5);
      applyStimulus(1, 1, 63'h3333, 31, 0, 5, 32'h3FFF_FFFF);
      bus.redirect_ready = 1'b1;
      applyStimulus(0, 0, 63'h0, 0, 0, 0, 32'h0);
      bus.redirect_ready = 1'b0;

      // Older replacement while pending, killed and equal-age reports ignored
      bus.commit_head = 5'd0;
      setAlu(0, 10, 63'hA0, 0, 3'd2);
      applyStimulus(1, 1, 63'hA0, 10, 0, 2, 32'hFFFF_F800);
      setAlu(1, 7, 63'h70, 1, 3'd6);
      applyStimulus(1, 1, 63'h70, 7, 1, 6, 32'hFFFF_FF00);
      setAlu(0, 12, 63'hC0, 0, 3'd4);
      applyStimulus(1, 1, 63'h70, 7, 1, 6, 32'hFFFF_FF00);
      setAlu(0, 7, 63'h77, 0, 3'd1);
      applyStimulus(1, 1, 63'h70, 7, 1, 6, 32'hFFFF_FF00);
      bus.redirect_ready = 1'b1;
      applyStimulus(0, 0, 63'h0, 0, 0, 0, 32'h0);
      bus.redirect_ready = 1'b0;

      // Branch at age NCOMMIT-1 kills nothing but still redirects
      bus.commit_head = 5'd6;
      setAlu(1, 5, 63'h55, 0, 3'd7);
      applyStimulus(1, 1, 63'h55, 5, 0, 7, 32'h0);
      bus.redirect_ready = 1'b1;
      applyStimulus(0, 0, 63'h0, 0, 0, 0, 32'h0);
      bus.redirect_ready = 1'b0;

      // Handshake with a same-cycle older candidate stays pending
      bus.commit_head = 5'd0;
      setAlu(0, 10, 63'hA0, 0, 3'd2);
      applyStimulus(1, 1, 63'hA0, 10, 0, 2, 32'hFFFF_F800);
      bus.redirect_ready = 1'b1;
      setAlu(0, 9, 63'h90, 1, 3'd3);
      applyStimulus(1, 1, 63'h90, 9, 1, 3, 32'hFFFF_FC00);
      applyStimulus(0, 0, 63'h0, 0, 0, 0, 32'h0);
      bus.redirect_ready = 1'b0;

      // Handshake with a same-cycle younger (killed) candidate goes idle
      setAlu(0, 10, 63'hA0, 0, 3'd2);
      applyStimulus(1, 1, 63'hA0, 10, 0, 2, 32'hFFFF_F800);
      bus.redirect_ready = 1'b1;
      setAlu(0, 11, 63'hB0, 1, 3'd1);
      applyStimulus(0, 0, 63'h0, 0, 0, 0, 32'h0);

      // Back-to-back loads with ready held high
      setAlu(0, 3, 63'h30, 0, 3'd1);
      applyStimulus(1, 1, 63'h30, 3, 0, 1, 32'hFFFF_FFF0);
      setAlu(1, 2, 63'h20, 1, 3'd2);
      applyStimulus(1, 1, 63'h20, 2, 1, 2, 32'hFFFF_FFF8);
      applyStimulus(0, 0, 63'h0, 0, 0, 0, 32'h0);
      bus.redirect_ready = 1'b0;

      // Equal addresses: lowest ALU wins; head advance leaves the mask alone
      setAlu(0, 4, 63'h40, 1, 3'd4);
      setAlu(1, 4, 63'h44, 0, 3'd5);
      applyStimulus(1, 1, 63'h40, 4, 1, 4, 32'hFFFF_FFE0);
      bus.commit_head = 5'd2;
      applyStimulus(1, 1, 63'h40, 4, 1, 4, 32'hFFFF_FFE0);

      // Reset mid-pend with a report on the same edge
      reset = 1'b1;
      setAlu(1, 1, 63'h11, 1, 3'd1);
      applyStimulus(1, 0, 63'h0, 0, 0, 0, 32'h0);
      reset = 1'b0;
      bus.commit_head = 5'd0;
      applyStimulus(1, 0, 63'h0, 0, 0, 0, 32'h0);

      repeat (4) @(posedge clk);
      while (scoreQ.size() > 0) begin
         exp_t left;
         left = scoreQ.pop_front();
         testsRun++;
         failCount++;
         $display("[TB] FAIL unchecked cycle%0d: got none, want check", left.cyc);
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/alu_br_resolve.md
# alu_br_resolve

Commit-side receiver for the branch-resolution outputs of the combined-branch ALUs. It takes the per-ALU mispredict reports (`commit_alu_br_*`) and keeps the oldest one relative to the commit head. It then drives `commit_kill_0`, a kill mask over every younger commit entry; this is the same mask the ALUs sample to suppress wrong-path results. It also holds a fetch redirect, with valid/ready handshake, until fetch accepts it.

## Interface
Parameters:
- `NALU`, 2, number of ALU branch-report ports
- `NCOMMIT`, 32, commit-buffer entries (power of 2)
- `LNCOMMIT`, 5, log2(NCOMMIT)
- `RV`, 64, register width; PCs carried as `[RV-1:1]`
- `BDEC`, 4, low PC bits carried for predictor update

Ports (clock and reset first):
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `commit_head` in LNCOMMIT: index of oldest in-flight commit entry
- `alu_br_enable` in NALU: per-ALU mispredict report valid (one-cycle pulse)
- `alu_br` in NALU*(RV-1): per-ALU correct target PC[RV-1:1], ALU k at slice k
- `alu_br_addr` in NALU*LNCOMMIT: per-ALU commit entry of the branch
- `alu_br_short` in NALU: per-ALU branch was a 16-bit instruction
- `alu_br_dec` in NALU*(BDEC-1): per-ALU branch PC[BDEC-1:1]
- `commit_kill_0` out NCOMMIT: kill mask, bit i = entry i is wrong-path
- `redirect_valid` out 1: fetch redirect pending
- `redirect_ready` in 1: fetch accepts redirect
- `redirect_pc` out RV-1: redirect target PC[RV-1:1]
- `redirect_addr` out LNCOMMIT: commit entry of the resolving branch
- `redirect_short` out 1: resolving branch was short
- `redirect_dec` out BDEC-1: resolving branch PC[BDEC-1:1]

## Operation
- Age: `age(x) = (x - commit_head) mod NCOMMIT`, computed as an LNCOMMIT-bit unsigned subtract. Smaller age means older.
- Candidate filter: ALU k is a candidate when `alu_br_enable[k]` is set and `commit_kill_0[alu_br_addr_k]` is 0 (an already-killed branch is ignored).
- Selection: the minimum-age candidate wins. On equal `addr` (a protocol violation), the lowest k wins.
- States: IDLE and PEND.
  - IDLE with any candidate: go to PEND and load the winner.
  - PEND with `redirect_ready` set: the handshake completes. Go to IDLE and clear the mask, unless a same-cycle candidate exists.
  - A same-cycle candidate is filtered against the old mask. If one survives, it is loaded and the state stays PEND, with `redirect_valid` held.
  - PEND without ready: a candidate is loaded only if `age(cand) < age(redirect_addr)`. Otherwise state is held.
- Load: `redirect_pc/addr/short/dec` take the winner's fields, and `commit_kill_0[i] = (age(i) > age(winner))` for all i.
  - The newly loaded mask replaces the old one. It never ORs into it.
- Branch at age NCOMMIT-1: mask all zero; the redirect is still issued.
- The `commit_head` advance is ignored for ordering; ages are always recomputed from the current head.
- Payload changes while `redirect_valid` is 1 only by an older replacement. Fetch samples on `valid & ready`.

## Timing
- Reset values: state IDLE, `redirect_valid` 0, `commit_kill_0` 0, `redirect_pc` 0, `redirect_addr` 0, `redirect_short` 0, `redirect_dec` 0.
- Reset mid-PEND: at the next edge all outputs return to their reset values; any pending redirect is dropped.
- Latency: `alu_br_enable` at edge N gives `redirect_valid` and `commit_kill_0` registered at N+1. There is no combinational input-to-output path.
- Both outputs come directly from flops, so the ALU sees the kill mask in the cycle after resolution.
- `commit_kill_0` is held constant for the whole of PEND except at an older replacement. It is 0 in the cycle after the handshake if no new load occurs.
- Accept throughput: one load per cycle. Back-to-back handshakes are supported (ready held high, fresh candidate every cycle).

## Test plan
- Single report: head=0, ALU0 addr=5, pc=0x1000, short=1 → next cycle valid=1, pc=0x1000, addr=5, short=1, mask=0xFFFFFFC0. With ready=1 that cycle → IDLE, mask=0.
- Simultaneous: head=30, ALU0 addr=2 (age 4), ALU1 addr=31 (age 1) → addr=31 wins; mask bits 0..29=1, 30..31=0.
- Older replacement in PEND: pending addr=10 (head=0), ready=0; ALU1 addr=7 (not killed) → addr 7 loaded, mask bits 8..31=1. Then ALU0 addr=12 → ignored (killed).
- Wrap boundary: head=6, branch addr=5 (age 31) → mask=0, valid=1.
- Handshake plus new candidate: pending addr=10, ready=1, same cycle ALU0 addr=9 → stays PEND with addr 9. Same setup with addr=11 → IDLE, mask 0.
- Reset asserted during PEND with a report on the same edge → next cycle all outputs 0, IDLE.
